// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment pattern reader.
package seg7_pkg;

  // Active-low segment patterns, bit i drives segment i (0=a ... 6=g).
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLocked
  } state_e;

  // The display-side decoder; the reader's lookup is defined as its inverse.
  function automatic logic [6:0] seg7_encode(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'd0:    seg = Seg0;
      3'd1:    seg = Seg1;
      3'd2:    seg = Seg2;
      3'd3:    seg = Seg3;
      3'd4:    seg = Seg4;
      3'd5:    seg = Seg5;
      3'd6:    seg = Seg6;
      default: seg = Seg7;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Segment input and decoded-result bundle between the display side and the reader.
interface seg7_if;
  logic [6:0] S;
  logic [2:0] Digit;
  logic       Valid;
  logic       Error;
  logic       Blank;
  logic [7:0] Count;

  modport master (output S, input Digit, input Valid, input Error, input Blank, input Count);
  modport slave  (input S, output Digit, output Valid, output Error, output Blank, output Count);
endinterface

// File: rtl/seg7_lookup.sv
// Combinational pattern-to-code lookup; exact inverse of seg7_encode.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] code,
  output logic       hit,
  output logic       is_blank
);

  // Match the pattern against every encoded digit.
  always_comb begin
    code     = 3'd0;
    hit      = 1'b0;
    is_blank = (pattern == SegBlank);
    for (int unsigned i = 0; i < 8; i++) begin
      if (pattern == seg7_encode(3'(i))) begin
        code = 3'(i);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounced reader of an asynchronous active-low seven-segment bus.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE = 4  // legal 1..15
) (
  input logic  Clock,
  input logic  Reset,
  seg7_if.slave bus
);

  localparam logic [3:0] StableM1 = 4'(STABLE - 1);

  logic [6:0] sync1_q, sample_q;
  logic [6:0] cand_q, cand_d;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] digit_q, digit_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic       blank_q, blank_d;
  logic [7:0] count_q, count_d;

  logic [2:0] lk_code;
  logic       lk_hit;
  logic       lk_blank;

  seg7_lookup u_lookup (
    .pattern  (cand_q),
    .code     (lk_code),
    .hit      (lk_hit),
    .is_blank (lk_blank)
  );

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= SegBlank;
      sample_q <= SegBlank;
    end else begin
      sync1_q  <= bus.S;
      sample_q <= sync1_q;
    end
  end

  // FSM and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cand_q  <= SegBlank;
      cnt_q   <= 4'd0;
      digit_q <= 3'd0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      blank_q <= 1'b1;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      error_q <= error_d;
      blank_q <= blank_d;
      count_q <= count_d;
    end
  end

  // Next-state: any change restarts settling; a full stable run accepts the candidate.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    blank_d = blank_q;
    count_d = count_q;

    if (sample_q != cand_q) begin
      cand_d  = sample_q;
      cnt_d   = 4'd0;
      state_d = StSettle;
    end else begin
      unique case (state_q)
        StIdle, StLocked: ;
        StSettle: begin
          if (cnt_q == StableM1) begin
            state_d = StLocked;
            cnt_d   = 4'd0;
            if (lk_hit) begin
              digit_d = lk_code;
              valid_d = 1'b1;
              count_d = count_q + 8'd1;
              blank_d = 1'b0;
            end else if (lk_blank) begin
              blank_d = 1'b1;
            end else begin
              error_d = 1'b1;
              blank_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.Digit = digit_q;
  assign bus.Valid = valid_q;
  assign bus.Error = error_q;
  assign bus.Blank = blank_q;
  assign bus.Count = count_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE=4.
module tb_seg7_reader;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  seg7_if bus_if ();

  seg7_reader #(.STABLE(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  logic [6:0] lk_pattern;
  logic [2:0] lk_code;
  logic       lk_hit;
  logic       lk_blank;

  seg7_lookup u_lk (
    .pattern  (lk_pattern),
    .code     (lk_code),
    .hit      (lk_hit),
    .is_blank (lk_blank)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] pat [8];
  logic [7:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then observe on the falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    check("valid_error_exclusive", 32'(bus_if.Valid & bus_if.Error), 32'd0);
  endtask

  // n edges after an S change; pulses allowed only on the last edge.
  task automatic run(input int n, input logic ev, input logic ee);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k < n) begin
        check("early_valid", 32'(bus_if.Valid), 32'd0);
        check("early_error", 32'(bus_if.Error), 32'd0);
      end else begin
        check("edge_valid", 32'(bus_if.Valid), 32'(ev));
        check("edge_error", 32'(bus_if.Error), 32'(ee));
      end
    end
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check("quiet_valid", 32'(bus_if.Valid), 32'd0);
      check("quiet_error", 32'(bus_if.Error), 32'd0);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] d, input logic b,
                             input logic [7:0] c);
    check({tag, "_digit"}, 32'(bus_if.Digit), 32'(d));
    check({tag, "_blank"}, 32'(bus_if.Blank), 32'(b));
    check({tag, "_count"}, 32'(bus_if.Count), 32'(c));
  endtask

  initial begin
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    bus_if.S   = 7'b1111111;
    lk_pattern = 7'b1111111;

    // Reset state
    @(negedge Clock);
    @(negedge Clock);
    check_state("reset", 3'd0, 1'b1, 8'd0);
    check("reset_valid", 32'(bus_if.Valid), 32'd0);
    check("reset_error", 32'(bus_if.Error), 32'd0);
    Reset = 1'b0;

    // Blank after release: stays idle, no pulses
    quiet(10);
    check_state("idle_blank", 3'd0, 1'b1, 8'd0);

    // Digit 3, accepted exactly at edge 7
    bus_if.S = 7'b0110000;
    run(7, 1'b1, 1'b0);
    check_state("digit3", 3'd3, 1'b0, 8'd1);
    quiet(5);
    check_state("digit3_hold", 3'd3, 1'b0, 8'd1);

    // 5 held only 3 cycles, then 7: single acceptance of 7
    bus_if.S = 7'b0010010;
    quiet(3);
    bus_if.S = 7'b1111000;
    run(7, 1'b1, 1'b0);
    check_state("digit7", 3'd7, 1'b0, 8'd2);

    // Digit 5 then blank
    bus_if.S = 7'b0010010;
    run(7, 1'b1, 1'b0);
    check_state("digit5", 3'd5, 1'b0, 8'd3);
    bus_if.S = 7'b1111111;
    run(6, 1'b0, 1'b0);
    check("blank_not_yet", 32'(bus_if.Blank), 32'd0);
    run(1, 1'b0, 1'b0);
    check_state("blank", 3'd5, 1'b1, 8'd3);

    // Non-digit pattern: one-cycle Error
    bus_if.S = 7'b0000000;
    run(7, 1'b0, 1'b1);
    check_state("nondigit", 3'd5, 1'b0, 8'd3);
    step();
    check("error_one_cycle", 32'(bus_if.Error), 32'd0);

    // Reset two cycles into settling, full latency after release
    bus_if.S = 7'b1111001;
    quiet(5);
    Reset = 1'b1;
    #1;
    check_state("async_reset", 3'd0, 1'b1, 8'd0);
    check("async_reset_valid", 32'(bus_if.Valid), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    run(7, 1'b1, 1'b0);
    check_state("after_reset_digit1", 3'd1, 1'b0, 8'd1);

    // Count wrap over 256 alternating 0/1 acceptances from reset
    bus_if.S = 7'b1111111;
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      bus_if.S = (i % 2 == 1) ? pat[1] : pat[0];
      run(7, 1'b1, 1'b0);
      exp_cnt = exp_cnt + 8'd1;
      check("loop_count", 32'(bus_if.Count), 32'(exp_cnt));
      check("loop_digit", 32'(bus_if.Digit), 32'(i % 2));
    end
    check("count_wrapped", 32'(bus_if.Count), 32'd0);

    // Lookup is the inverse of the display encoding
    for (int i = 0; i < 8; i++) begin
      lk_pattern = pat[i];
      #1;
      check("lookup_code", 32'(lk_code), 32'(i));
      check("lookup_hit", 32'(lk_hit), 32'd1);
      check("lookup_reencode", 32'(pat[lk_code]), 32'(lk_pattern));
    end
    lk_pattern = 7'b1111111;
    #1;
    check("lookup_blank_hit", 32'(lk_hit), 32'd0);
    check("lookup_blank_flag", 32'(lk_blank), 32'd1);
    lk_pattern = 7'b0000000;
    #1;
    check("lookup_bad_hit", 32'(lk_hit), 32'd0);
    check("lookup_bad_blank", 32'(lk_blank), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE, default 4: consecutive matching sample cycles needed to accept a pattern; the legal range SHALL be 1..15.
REQ-002 Clock  input  1  single rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 S  input  7  active-low segment lines, asynchronous to Clock; S[i] is segment i (0=a ... 6=g).
REQ-005 Digit  output  3  last accepted digit code, 0..7.
REQ-006 Valid  output  1  one-cycle pulse when a digit pattern is accepted.
REQ-007 Error  output  1  one-cycle pulse when an accepted pattern is neither a digit nor blank.
REQ-008 Blank  output  1  level; the last accepted pattern was blank (S=7'b1111111).
REQ-009 Count  output  8  number of Valid pulses, modulo 256.

Function
REQ-010 S SHALL pass through a 2-flop synchronizer; the second flop output is "sample".
REQ-011 Digit patterns, S[6:0], active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-012 The FSM SHALL have three states: IDLE, SETTLE and LOCKED, plus a 7-bit candidate register and a 4-bit counter cnt.
REQ-013 In any state, sample != candidate SHALL load candidate, clear cnt and enter SETTLE, with no output pulse.
REQ-014 In SETTLE with sample == candidate, cnt SHALL increment; when cnt==STABLE-1 on such a cycle, the next edge SHALL accept the pattern and enter LOCKED.
REQ-015 On acceptance of a digit pattern: Digit set to the code, Valid pulsed 1 cycle, Count incremented, Blank cleared.
REQ-016 On acceptance of the blank pattern: Blank set, and Digit, Valid and Count unchanged.
REQ-017 On acceptance of any other pattern: Error pulsed 1 cycle, Blank cleared, and Digit and Count unchanged.
REQ-018 Latency from an S change to the Valid/Error/Blank update SHALL be STABLE+3 clock edges.
REQ-019 A change during SETTLE shorter than STABLE cycles SHALL restart settling; no output SHALL change.
REQ-020 Leaving LOCKED and then re-accepting the same digit SHALL pulse Valid again and increment Count (no duplicate suppression).
REQ-021 Valid and Error SHALL never be high in the same cycle; each SHALL be high for at most one cycle per acceptance.
REQ-022 Count SHALL wrap 255 -> 0.
REQ-023 IDLE and LOCKED SHALL hold while sample == candidate, with no output activity.

Reset
REQ-024 Reset high SHALL immediately force: synchronizer flops and candidate = 1111111, state IDLE, cnt 0, Digit 000, Valid 0, Error 0, Blank 1, Count 0.
REQ-025 Reset asserted mid-SETTLE SHALL discard the partial count; after release, a non-blank S SHALL require the full STABLE+3 latency.
REQ-026 After release with S blank, the block SHALL stay in IDLE with Blank=1 and no pulses.

Structure
REQ-027 Package seg7_pkg SHALL hold:
- the eight digit pattern constants and the BLANK constant;
- the FSM state typedef (IDLE/SETTLE/LOCKED).
REQ-028 Sub-module seg7_lookup SHALL be combinational:
- input: 7-bit pattern;
- outputs: 3-bit code, hit, is_blank.
REQ-029 seg7_lookup SHALL be the exact inverse of the existing 3-bit-to-segment display decoder for codes 0..7.

Verification
REQ-030 STABLE=4, reset released, S=0110000 held -> Valid pulse at edge 7 after the change, Digit=3, Count=1, Blank=0.
REQ-031 S=0010010 held for 3 cycles, then S=1111000 held -> no pulse for the first pattern; Valid once with Digit=7.
REQ-032 S=1111111 after Digit=5 -> Blank=1, Digit stays 5, no Valid, Count unchanged.
REQ-033 S=0000000 (not a digit) held -> Error pulse for 1 cycle, Digit unchanged, Valid 0.
REQ-034 Reset asserted 2 cycles into SETTLE, S=1111001 held -> outputs at reset values at once; Valid at edge STABLE+3 after release, Digit=1.
REQ-035 256 alternating 0/1 digit acceptances -> Count returns to 0; no Error; for every seg7_lookup code, re-encoding through the display decoder yields the original pattern.
